// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter: the fetch-side (i) and memory-side (d) requesters share one
// bus. A single transaction is outstanding at a time, and its grant is held until the response returns.
module mem_bus_arbiter #(
  parameter bit DPRIO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [63:0] i_addr,
  output logic        i_addr_ok,
  output logic        i_data_ok,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [7:0]  d_strobe,
  input  logic [63:0] d_wdata,
  output logic        d_addr_ok,
  output logic        d_data_ok,
  output logic [63:0] d_rdata,
  output logic        m_valid,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [7:0]  m_strobe,
  output logic [63:0] m_wdata,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [63:0] m_rdata,
  output logic        grant_d
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t state_q, state_d;
  logic   grant_d_q, grant_d_d;   // 1: the current or last grant went to the d requester
  logic   last_d_q, last_d_d;     // 1: the last completed transaction served d

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_d_q <= 1'b0;
      last_d_q  <= 1'b0;
    end else begin
      // NOTE: state registers take non-blocking assignments so that every flop samples pre-edge values.
      state_q   <= state_d;
      grant_d_q <= grant_d_d;
      last_d_q  <= last_d_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default value first, so no path through the case can infer a latch.
    state_d   = state_q;
    grant_d_d = grant_d_q;
    last_d_d  = last_d_q;
    i_addr_ok = 1'b0;
    i_data_ok = 1'b0;
    i_rdata   = '0;
    d_addr_ok = 1'b0;
    d_data_ok = 1'b0;
    d_rdata   = '0;
    m_valid   = 1'b0;
    m_addr    = '0;
    m_size    = '0;
    m_strobe  = '0;
    m_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        // m_rvalid is ignored here, which drops any response left over from before a reset.
        if (i_valid || d_valid) begin
          state_d = ISSUE;
          if (i_valid && d_valid) grant_d_d = DPRIO ? 1'b1 : ~last_d_q;
          else                    grant_d_d = d_valid;
        end
      end

      ISSUE: begin
        m_valid = 1'b1;
        if (grant_d_q) begin
          m_addr   = d_addr;
          m_size   = d_size;
          m_strobe = d_strobe;
          m_wdata  = d_wdata;
        end else begin
          m_addr   = i_addr;
          m_size   = 3'b010;
        end
        if (m_ready) begin
          d_addr_ok = grant_d_q;
          i_addr_ok = ~grant_d_q;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        if (m_rvalid) begin
          if (grant_d_q) begin
            d_data_ok = 1'b1;
            d_rdata   = m_rdata;
          end else begin
            i_data_ok = 1'b1;
            i_rdata   = i_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
          end
          last_d_d = grant_d_q;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign grant_d = grant_d_q;

endmodule
